reconstructor_dividendo_segmentado: RTL and testbench
=====================================================

Name: reconstructor_dividendo_segmentado

Overview:
- Pipelined signed inverse of the team's segmented divider: computes Num = Coc*Den + Res with a shift-and-add pipeline, one multiplier bit per stage.
- Accepts one operation per clock.
- Sits beside the divider: recombines its quotient/remainder outputs for self-check, and serves as the datapath's general signed multiply-accumulate.

Parameters:
- tamanyo, 32, operand width in bits; must be ≥ 2.
- etapas, tamanyo+2, total pipeline depth: 1 input stage + tamanyo add stages + 1 output stage. Derived; not to be overridden.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RSTa  input  1  asynchronous active-low reset.
- Start  input  1  operand-valid strobe; sampled every rising edge.
- Coc  input  tamanyo  signed (two's complement) multiplier / quotient.
- Den  input  tamanyo  signed multiplicand / divisor.
- Res  input  tamanyo  signed addend / remainder.
- Num  output  2*tamanyo  signed result Coc*Den+Res; '0 when Done=0.
- Ovf  output  1  Num not representable as a tamanyo-bit signed value; 0 when Done=0.
- Done  output  1  result valid this cycle.
- Err  output  1  residue-consistency error (see Optional Feature); 0 when Done=0.

Behaviour:
- Reset (RSTa=0, asynchronous): all stage valid bits, operands, accumulators and signs cleared immediately. Done=0, Num='0, Ovf=0, Err=0 while reset is held and on the first cycle after release. An in-flight operation is discarded and never produces Done.
- Input stage, edge k with Start=1:
  - Register the sign bits SignCoc and SignDen.
  - Register magnitudes |Coc| and |Den| as unsigned tamanyo-bit values. −2^(tamanyo−1) maps to 2^(tamanyo−1) with no saturation.
  - Register Res sign-extended to 2*tamanyo bits.
  - Clear the accumulator ACC (2*tamanyo bits).
- Input stage with Start=0: the valid bit becomes 0 (bubble). Data registers may hold stale values; downstream logic must ignore them.
- Add stage j (j = 0..tamanyo−1):
  - If bit j of |Coc| is 1: ACC <= ACC + (|Den| << j). Otherwise ACC is passed through unchanged.
  - Operands, signs, Res and the valid bit shift forward one stage per clock.
  - A stage updates only when its incoming valid bit is 1.
- Output stage:
  - P = (SignCoc ^ SignDen) ? −ACC : ACC.
  - Num register <= P + Res_ext, with 2*tamanyo-bit wrap. The range is exact; no wrap occurs for legal inputs.
  - Ovf <= (Num[2*tamanyo−1:tamanyo−1] not all equal).
- Latency: Start sampled at edge k gives Done=1 with valid Num/Ovf/Err during the cycle after edge k+etapas−1 (34 edges for tamanyo=32, i.e. Done first seen after edge k+33).
- Throughput: one result per clock. Back-to-back Start pulses produce back-to-back Done in the same order. Gaps are preserved.
- Den=0 or Coc=0: Num = Res_ext. This is legal and needs no special case.
- Outputs are gated combinationally by Done: Num/Ovf/Err are forced to 0 when Done=0.
- No stall or backpressure: the consumer must accept each result in its Done cycle.

Optional Feature:
- Macro: RESIDUE_CHECK_EN.
- Defined:
  - The input stage computes chk = (Res != 0) && ((|Res| >= |Den|) || (Res sign != Coc-sign-of-dividend rule: Res sign must equal sign of final Num)).
  - Pipeline the chk flag. At the output, Err = chk_pipe | (Res != 0 && Res[msb] != Num[2*tamanyo−1]).
  - Err is valid with Done, marking quotient/remainder pairs the divider could not have produced.
- Undefined: no check logic is instantiated; Err is tied to 0.

Decomposition:
- Package divisor_pkg:
  - localparam defaults for tamanyo.
  - typedef struct packed etapa_t {valid, SignCoc, SignDen, magCoc, magDen, Res_ext, ACC, chk}, shared by all stages.
  - function abs_mag(tamanyo-bit signed) returning unsigned magnitude.
- One sub-module, etapa_suma_desplazamiento:
  - Parameterised by stage index j.
  - Registered etapa_t in/out with CLK/RSTa; performs the conditional shifted add.
- The top level generates tamanyo instances between the input and output stages.

Test Plan (tamanyo=32):
- Basic: Start 1 cycle with Coc=7, Den=3, Res=1 -> Done exactly 34 edges later, Num=22, Ovf=0, Err=0; Done=0 and Num=0 on the surrounding cycles.
- Signs: Coc=−7, Den=3, Res=−1 -> Num=−22 (0xFFFF_FFFF_FFFF_FFEA), Ovf=0. Then Coc=7, Den=−3, Res=1 -> Num=−20.
- Streaming: Start held 4 cycles with (Coc,Den,Res) = (1,1,0), (2,3,1), (−5,5,0), (0,9,4) -> 4 consecutive Done cycles giving Num = 1, 7, −25, 4.
- Extremes and overflow:
  - Coc=Den=−2^31, Res=0 -> Num=2^62, Ovf=1.
  - Coc=0x4000_0000, Den=4 -> Num=2^32, Ovf=1.
  - Coc=0x7FFF_FFFF, Den=1, Res=0 -> Ovf=0.
- Reset mid-operation: Start at edge k, RSTa pulsed low between edges k+10 and k+11 -> no Done ever appears for that operation. A new Start after release completes normally.
- RESIDUE_CHECK_EN:
  - Coc=2, Den=3, Res=5 -> Err=1.
  - Coc=2, Den=3, Res=2 -> Err=0.
  - With the macro undefined, both cases give Err=0.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared definitions for the segmented divider family.
// Holds the default operand width, the per-stage payload carried down the
// reconstruction pipeline, and the two's-complement magnitude helper.
package divisor_pkg;

    // Operand width; the top-level 'tamanyo' parameter must match this value
    // because it sizes etapa_t.
    localparam int unsigned TAMANYO  = 32;
    localparam int unsigned TAMANYO2 = 2 * TAMANYO;

    // Payload registered by every pipeline stage.
    typedef struct packed {
        logic                valid;
        logic                SignCoc;
        logic                SignDen;
        logic [TAMANYO-1:0]  magCoc;
        logic [TAMANYO-1:0]  magDen;
        logic [TAMANYO2-1:0] Res_ext;
        logic [TAMANYO2-1:0] ACC;
        logic                chk;
    } etapa_t;

    // Unsigned magnitude of a signed value; the most negative value maps to
    // 2^(TAMANYO-1) without saturation.
    function automatic logic [TAMANYO-1:0] abs_mag(input logic [TAMANYO-1:0] x);
        return x[TAMANYO-1] ? ((~x) + TAMANYO'(1)) : x;
    endfunction

endpackage

// File: rtl/etapa_suma_desplazamiento.sv
// One shift-and-add stage of the reconstruction pipeline.
// Stage j adds |Den| << j into the accumulator when bit j of |Coc| is set and
// forwards the rest of the payload unchanged.
// Ports:
//   CLK, RSTa : clock, asynchronous active-low reset
//   entrada   : payload from the previous stage
//   salida    : registered payload towards the next stage
module etapa_suma_desplazamiento
    import divisor_pkg::*;
#(
    parameter int unsigned j = 0
) (
    input  logic   CLK,
    input  logic   RSTa,
    input  etapa_t entrada,
    output etapa_t salida
);

    logic [TAMANYO2-1:0] sumando;
    etapa_t              siguiente;

    // Conditional shifted add for this multiplier bit.
    always_comb begin
        sumando   = TAMANYO2'(entrada.magDen) << j;
        siguiente = entrada;
        if (entrada.magCoc[j]) begin
            siguiente.ACC = entrada.ACC + sumando;
        end
    end

    // Data only moves on a valid slot; a bubble just clears the valid bit.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            salida <= '0;
        end else if (entrada.valid) begin
            salida <= siguiente;
        end else begin
            salida.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/reconstructor_dividendo_segmentado.sv
// Pipelined signed reconstruction Num = Coc*Den + Res, one multiplier bit per
// stage, one operation accepted per clock, fixed latency of 'etapas' edges.
// Optional residue consistency check enabled by defining RESIDUE_CHECK_EN;
// without it Err is tied to 0.
// Ports:
//   CLK, RSTa      : clock, asynchronous active-low reset
//   Start          : operand-valid strobe
//   Coc, Den, Res  : signed multiplier, multiplicand, addend
//   Num            : signed result, zero outside Done cycles
//   Ovf            : Num does not fit in tamanyo signed bits
//   Done           : result valid this cycle
//   Err            : quotient/remainder pair inconsistent with a division
module reconstructor_dividendo_segmentado
    import divisor_pkg::*;
#(
    parameter int unsigned tamanyo = TAMANYO
) (
    input  logic                   CLK,
    input  logic                   RSTa,
    input  logic                   Start,
    input  logic [tamanyo-1:0]     Coc,
    input  logic [tamanyo-1:0]     Den,
    input  logic [tamanyo-1:0]     Res,
    output logic [2*tamanyo-1:0]   Num,
    output logic                   Ovf,
    output logic                   Done,
    output logic                   Err
);

    localparam int unsigned etapas  = tamanyo + 2;
    localparam int unsigned n_sumas = etapas - 2;

    etapa_t entrada_d;
    etapa_t etapa_ini;
    etapa_t cadena [0:n_sumas];
    etapa_t fin;

    logic [2*tamanyo-1:0] producto;
    logic [2*tamanyo-1:0] num_d;
    logic                 ovf_d;
    logic                 err_d;

    logic [2*tamanyo-1:0] num_q;
    logic                 ovf_q;
    logic                 err_q;
    logic                 done_q;

    // Input stage payload: signs, magnitudes, sign-extended addend, clear ACC.
    always_comb begin
        entrada_d         = '0;
        entrada_d.valid   = 1'b1;
        entrada_d.SignCoc = Coc[tamanyo-1];
        entrada_d.SignDen = Den[tamanyo-1];
        entrada_d.magCoc  = abs_mag(Coc);
        entrada_d.magDen  = abs_mag(Den);
        entrada_d.Res_ext = {{tamanyo{Res[tamanyo-1]}}, Res};
        entrada_d.ACC     = '0;
`ifdef RESIDUE_CHECK_EN
        // A true remainder is strictly smaller in magnitude than the divisor.
        entrada_d.chk     = (Res != '0) && (abs_mag(Res) >= abs_mag(Den));
`endif
    end

    // Input stage register; Start=0 inserts a bubble and leaves data stale.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            etapa_ini <= '0;
        end else if (Start) begin
            etapa_ini <= entrada_d;
        end else begin
            etapa_ini.valid <= 1'b0;
        end
    end

    assign cadena[0] = etapa_ini;

    // One add stage per multiplier bit.
    for (genvar g = 0; g < n_sumas; g++) begin : g_suma
        etapa_suma_desplazamiento #(
            .j (g)
        ) u_etapa (
            .CLK     (CLK),
            .RSTa    (RSTa),
            .entrada (cadena[g]),
            .salida  (cadena[g+1])
        );
    end

    assign fin = cadena[n_sumas];

    // Output stage: apply the product sign, add the addend, range check.
    always_comb begin
        producto = (fin.SignCoc ^ fin.SignDen) ? ((~fin.ACC) + (2*tamanyo)'(1)) : fin.ACC;
        num_d    = producto + fin.Res_ext;
        ovf_d    = !((&num_d[2*tamanyo-1:tamanyo-1]) || !(|num_d[2*tamanyo-1:tamanyo-1]));
`ifdef RESIDUE_CHECK_EN
        // A nonzero remainder must carry the sign of the dividend.
        err_d    = fin.chk | ((fin.Res_ext != '0) && (fin.Res_ext[2*tamanyo-1] != num_d[2*tamanyo-1]));
`else
        err_d    = 1'b0;
`endif
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            done_q <= 1'b0;
            num_q  <= '0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= fin.valid;
            if (fin.valid) begin
                num_q <= num_d;
                ovf_q <= ovf_d;
                err_q <= err_d;
            end
        end
    end

    // Result fields read as zero outside the Done cycle.
    assign Done = done_q;
    assign Num  = done_q ? num_q : '0;
    assign Ovf  = done_q & ovf_q;
    assign Err  = done_q & err_q;

    // Magnitudes are fully consumed by the add stages; chk only matters with the check.
    logic unused_fin;
    assign unused_fin = ^{fin.magCoc, fin.magDen, fin.chk};

endmodule

// File: tb/tb_reconstructor_dividendo_segmentado.sv
// Self-checking bench for reconstructor_dividendo_segmentado (tamanyo=32).
// An arithmetic reference model predicts every result and its Done cycle;
// a compare process checks all outputs on every falling edge.
module tb_reconstructor_dividendo_segmentado;

    localparam int unsigned W   = 32;
    localparam int unsigned LAT = 34;

    logic          CLK = 1'b0;
    logic          RSTa;
    logic          Start;
    logic [W-1:0]  Coc, Den, Res;
    logic [2*W-1:0] Num;
    logic          Ovf, Done, Err;

    reconstructor_dividendo_segmentado dut (
        .CLK   (CLK),
        .RSTa  (RSTa),
        .Start (Start),
        .Coc   (Coc),
        .Den   (Den),
        .Res   (Res),
        .Num   (Num),
        .Ovf   (Ovf),
        .Done  (Done),
        .Err   (Err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        longint         due;
        logic [2*W-1:0] num;
        logic           ovf;
        logic           err;
    } exp_t;

    exp_t   q[$];
    longint edge_n = 0;
    int     n_chk  = 0;
    int     n_fail = 0;

    always @(posedge CLK) edge_n <= edge_n + 1;

    function automatic void chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_n);
        end
    endfunction

    // Reference: plain signed 64-bit arithmetic.
    function automatic void model(input logic signed [W-1:0] c, input logic signed [W-1:0] d,
                                  input logic signed [W-1:0] r,
                                  output logic [2*W-1:0] num, output logic ovf, output logic err);
        longint n, ar, ad;
        n   = longint'(c) * longint'(d) + longint'(r);
        num = n;
        ovf = (longint'(int'(n)) != n);
        ar  = (r < 0) ? -longint'(r) : longint'(r);
        ad  = (d < 0) ? -longint'(d) : longint'(d);
`ifdef RESIDUE_CHECK_EN
        err = (r != 0) && ((ar >= ad) || ((r < 0) != (n < 0)));
`else
        err = 1'b0 | ((ar < 0) && (ad < 0));
`endif
    endfunction

    // Per-cycle comparison against the predicted stream.
    always @(negedge CLK) begin
        if (q.size() > 0 && q[0].due == edge_n) begin
            chk("done", {63'd0, Done}, 64'd1);
            chk("num",  Num, q[0].num);
            chk("ovf",  {63'd0, Ovf}, {63'd0, q[0].ovf});
            chk("err",  {63'd0, Err}, {63'd0, q[0].err});
            void'(q.pop_front());
        end else begin
            chk("idle_done", {63'd0, Done}, 64'd0);
            chk("idle_num",  Num, 64'd0);
            chk("idle_ovf",  {63'd0, Ovf}, 64'd0);
            chk("idle_err",  {63'd0, Err}, 64'd0);
        end
    end

    // Called at a falling edge; Start is sampled on the next rising edge.
    task automatic drive(input bit s, input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] r);
        exp_t e;
        Start = s;
        Coc   = c;
        Den   = d;
        Res   = r;
        if (s) begin
            model(c, d, r, e.num, e.ovf, e.err);
            e.due = edge_n + LAT;
            q.push_back(e);
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, $urandom, $urandom);
    endtask

    // Isolated operation with literal expectations on the DUT and the model.
    task automatic directo(input string nm, input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] r,
                           input logic [2*W-1:0] lnum, input logic lovf, input logic lerr);
        logic [2*W-1:0] mn;
        logic           mo, me;
        model(c, d, r, mn, mo, me);
        chk({nm, "_model_num"}, mn, lnum);
        chk({nm, "_model_err"}, {63'd0, me}, {63'd0, lerr});
        drive(1'b1, c, d, r);
        idle(LAT - 1);
        chk({nm, "_done"}, {63'd0, Done}, 64'd1);
        chk({nm, "_num"},  Num, lnum);
        chk({nm, "_ovf"},  {63'd0, Ovf}, {63'd0, lovf});
        chk({nm, "_err"},  {63'd0, Err}, {63'd0, lerr});
        idle(2);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        v = $urandom;
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return {{24{v[7]}}, v[7:0]};
            default: return v;
        endcase
    endfunction

`ifdef RESIDUE_CHECK_EN
    localparam logic ERR_BIG = 1'b1;
`else
    localparam logic ERR_BIG = 1'b0;
`endif

    initial begin
        RSTa  = 1'b0;
        Start = 1'b0;
        Coc   = '0;
        Den   = '0;
        Res   = '0;
        repeat (3) @(negedge CLK);
        chk("rst_done", {63'd0, Done}, 64'd0);
        chk("rst_num",  Num, 64'd0);
        chk("rst_ovf",  {63'd0, Ovf}, 64'd0);
        chk("rst_err",  {63'd0, Err}, 64'd0);
        RSTa = 1'b1;
        idle(2);

        directo("basic", 32'd7, 32'd3, 32'd1, 64'd22, 1'b0, 1'b0);
        directo("neg1", -32'sd7, 32'd3, -32'sd1, 64'hFFFF_FFFF_FFFF_FFEA, 1'b0, 1'b0);
        directo("neg2", 32'd7, -32'sd3, 32'd1, 64'hFFFF_FFFF_FFFF_FFEC, 1'b0, 1'b0);
        directo("minmin", 32'h8000_0000, 32'h8000_0000, 32'd0, 64'h4000_0000_0000_0000, 1'b1, 1'b0);
        directo("big", 32'h4000_0000, 32'd4, 32'd0, 64'h0000_0001_0000_0000, 1'b1, 1'b0);
        directo("maxpos", 32'h7FFF_FFFF, 32'd1, 32'd0, 64'h0000_0000_7FFF_FFFF, 1'b0, 1'b0);
        directo("den0", 32'd9, 32'd0, -32'sd4, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, ERR_BIG);
        directo("resbad", 32'd2, 32'd3, 32'd5, 64'd11, 1'b0, ERR_BIG);
        directo("resok", 32'd2, 32'd3, 32'd2, 64'd8, 1'b0, 1'b0);

        // Back-to-back stream of four operations.
        drive(1'b1, 32'd1, 32'd1, 32'd0);
        drive(1'b1, 32'd2, 32'd3, 32'd1);
        drive(1'b1, -32'sd5, 32'd5, 32'd0);
        drive(1'b1, 32'd0, 32'd9, 32'd4);
        idle(LAT - 4);
        chk("stream0", Num, 64'd1);
        idle(1);
        chk("stream1", Num, 64'd7);
        idle(1);
        chk("stream2", Num, 64'hFFFF_FFFF_FFFF_FFE7);
        idle(1);
        chk("stream3", Num, 64'd4);
        idle(1);
        chk("stream_end", {63'd0, Done}, 64'd0);
        idle(2);

        // Reset between edges k+10 and k+11 kills the in-flight operation.
        drive(1'b1, 32'd123, 32'd456, 32'd7);
        idle(10);
        RSTa = 1'b0;
        q.delete();
        #1;
        chk("midrst_done", {63'd0, Done}, 64'd0);
        chk("midrst_num",  Num, 64'd0);
        #1;
        RSTa = 1'b1;
        idle(LAT + 6);
        directo("postrst", 32'd5, -32'sd6, 32'd3, 64'hFFFF_FFFF_FFFF_FFE5, 1'b0, ERR_BIG);

        // Randomized traffic with gaps.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, pick(), pick(), pick());
        end
        idle(LAT + 4);
        chk("drain", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
